// File: rtl/and_mux_sweep.sv
// Exhaustive stimulus sweep of and_mux {sel,a,b,c,d} with per-vector response capture into resp.
// Optional idle gap between sel halves is compiled in with AND_MUX_SWEEP_GAP_EN.
module and_mux_sweep #(
  parameter int DWELL = 2,
  parameter int GAP   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        e,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        sel,
  output logic        busy,
  output logic        done,
  output logic [4:0]  idx,
  output logic [31:0] resp
);

  if (DWELL < 1 || DWELL > 255) begin : g_dwell_range
    $error("and_mux_sweep: DWELL must be 1..255");
  end
  if (GAP < 0 || GAP > 255) begin : g_gap_range
    $error("and_mux_sweep: GAP must be 0..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
`ifdef AND_MUX_SWEEP_GAP_EN
    S_GAP   = 2'd3,
`endif
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] DW_LAST = 8'(DWELL - 1);
`ifdef AND_MUX_SWEEP_GAP_EN
  localparam logic [7:0] GP_LAST = 8'(GAP - 1);
  localparam bit         GAP_ON  = (GAP > 0);
`endif

  state_t     state;
  logic [7:0] cnt;
`ifdef AND_MUX_SWEEP_GAP_EN
  logic [7:0] gcnt;
`endif

  // idx is cleared whenever not sweeping, so the mux pins follow it directly
  assign {sel, a, b, c, d} = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      resp  <= 32'd0;
      cnt   <= 8'd0;
`ifdef AND_MUX_SWEEP_GAP_EN
      gcnt  <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            resp  <= 32'd0;
            idx   <= 5'd0;
            busy  <= 1'b1;
            cnt   <= 8'd0;
            state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt == DW_LAST) begin
            resp[idx] <= e;
            cnt       <= 8'd0;
            if (idx == 5'd31) begin
              idx   <= 5'd0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
`ifdef AND_MUX_SWEEP_GAP_EN
            else if (idx == 5'd15 && GAP_ON) begin
              gcnt  <= 8'd0;
              state <= S_GAP;
            end
`endif
            else begin
              idx <= idx + 5'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
`ifdef AND_MUX_SWEEP_GAP_EN
        S_GAP: begin
          // vector 15 stays on the pins until sel is allowed to rise
          if (gcnt == GP_LAST) begin
            gcnt  <= 8'd0;
            idx   <= 5'd16;
            state <= S_DRIVE;
          end else begin
            gcnt <= gcnt + 8'd1;
          end
        end
`endif
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_mux_sweep.sv
// Randomized self-checking bench for and_mux_sweep: two instances (DWELL=2/GAP=3 and DWELL=1/GAP=0)
// checked cycle by cycle against a timeline model of the sweep.
module tb_and_mux_sweep;

`ifdef AND_MUX_SWEEP_GAP_EN
  localparam int G0 = 3;
`else
  localparam int G0 = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [2];
  logic        e     [2];
  logic        a [2], b [2], c [2], d [2], sel [2], busy [2], done [2];
  logic [4:0]  idx  [2];
  logic [31:0] resp [2];
  int          mode [2];
  bit          rtab [2][32];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  and_mux_sweep #(.DWELL(2), .GAP(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .e(e[0]),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .sel(sel[0]),
    .busy(busy[0]), .done(done[0]), .idx(idx[0]), .resp(resp[0])
  );

  and_mux_sweep #(.DWELL(1), .GAP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .e(e[1]),
    .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]), .sel(sel[1]),
    .busy(busy[1]), .done(done[1]), .idx(idx[1]), .resp(resp[1])
  );

  // Mux-under-test stand-ins: 0 -> a&b, 1 -> sel, 2 -> a, 3 -> random truth table
  function automatic bit rule(input int m, input logic [4:0] v);
    case (m)
      0:       return v[3] & v[2];
      1:       return v[4];
      default: return v[3];
    endcase
  endfunction

  assign e[0] = (mode[0] == 3) ? rtab[0][{sel[0], a[0], b[0], c[0], d[0]}]
                               : rule(mode[0], {sel[0], a[0], b[0], c[0], d[0]});
  assign e[1] = (mode[1] == 3) ? rtab[1][{sel[1], a[1], b[1], c[1], d[1]}]
                               : rule(mode[1], {sel[1], a[1], b[1], c[1], d[1]});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] status(input int u);
    return {busy[u], done[u], sel[u], a[u], b[u], c[u], d[u], idx[u]};
  endfunction

  // Vector on the pins during cycle t after the start edge; 32 = done cycle, 33 = idle after
  function automatic int vec_at(input int t, input int dw, input int g);
    if (t < 16 * dw)          return t / dw;
    if (t < 16 * dw + g)      return 15;
    if (t < 32 * dw + g)      return 16 + (t - 16 * dw - g) / dw;
    if (t == 32 * dw + g)     return 32;
    return 33;
  endfunction

  function automatic logic [31:0] captured(input int t, input int dw, input int g);
    logic [31:0] m = '0;
    for (int k = 0; k < 32; k++)
      if ((k + 1) * dw + (k >= 16 ? g : 0) <= t) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [11:0] exp_status(input int k);
    logic [4:0] kv;
    kv = 5'(k);
    if (k < 32)  return {2'b10, kv, kv};
    if (k == 32) return 12'b01_00000_00000;
    return 12'd0;
  endfunction

  function automatic logic [31:0] exp_resp(input int u, input int m);
    logic [31:0] r;
    for (int v = 0; v < 32; v++) r[v] = (m == 3) ? rtab[u][v] : rule(m, 5'(v));
    return r;
  endfunction

  task automatic sweep(input int u, input int m, input int dw, input int g,
                       input bit repulse, input string tag);
    logic [31:0] er;
    int          k;
    for (int v = 0; v < 32; v++) rtab[u][v] = bit'($urandom_range(0, 1));
    mode[u] = m;
    er = exp_resp(u, m);
    @(negedge clk);
    start[u] = 1'b1;
    @(posedge clk);
    for (int t = 0; t <= 32 * dw + g + 1; t++) begin
      @(negedge clk);
      start[u] = 1'b0;
      k = vec_at(t, dw, g);
      if (repulse && k == 5) start[u] = 1'b1;
      check({tag, "_st"}, 64'(status(u)), 64'(exp_status(k)));
      check({tag, "_resp"}, 64'(resp[u]), 64'(er & captured(t, dw, g)));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int ndone;
    logic [31:0] er;
    rst_n    = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    mode[0]  = 0;
    mode[1]  = 0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_st", 64'(status(u)), 64'd0);
      check("rst_resp", 64'(resp[u]), 64'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    sweep(0, 0, 2, G0, 1'b0, "ab_d2");
    check("ab_const", 64'(resp[0]), 64'h0000_0000_F000_F000);
    sweep(1, 1, 1, 0, 1'b0, "sel_d1");
    check("sel_const", 64'(resp[1]), 64'h0000_0000_FFFF_0000);
    sweep(0, 2, 2, G0, 1'b0, "a_gap");
    check("a_const", 64'(resp[0]), 64'h0000_0000_FF00_FF00);
    for (int r = 0; r < 3; r++) begin
      sweep(0, 3, 2, G0, 1'b0, "rnd_d2");
      sweep(1, 3, 1, 0, 1'b0, "rnd_d1");
    end
    sweep(0, 3, 2, G0, 1'b1, "repulse");

    // asynchronous abort mid-sweep at vector 10
    mode[0] = 2;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    k = 0;
    while (idx[0] != 5'd10 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reach_idx10", 64'(idx[0]), 64'd10);
    check("pre_rst_resp_nz", 64'(resp[0] != 0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_st", 64'(status(0)), 64'd0);
    check("abort_resp", 64'(resp[0]), 64'd0);
    @(negedge clk);
    check("abort_hold", 64'({status(0), resp[0]}), 64'd0);
    rst_n = 1'b1;
    sweep(0, 3, 2, G0, 1'b0, "post_rst");

    // start held high: back-to-back sweeps with a 34-cycle period
    for (int v = 0; v < 32; v++) rtab[1][v] = bit'($urandom_range(0, 1));
    mode[1] = 3;
    er = exp_resp(1, 3);
    ndone = 0;
    @(negedge clk);
    start[1] = 1'b1;
    @(posedge clk);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      k = t % 34;
      if (done[1]) ndone++;
      check("held_st", 64'(status(1)), 64'(exp_status(k)));
      if (k == 32) check("held_resp", 64'(resp[1]), 64'(er));
    end
    check("held_ndone", 64'(ndone), 64'd2);
    start[1] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
